otter_branch_predictor: RTL
===========================

OTTER_BRANCH_PREDICTOR -- requirements
Module: otter_branch_predictor

Interface
REQ-001 The block SHALL have parameter ENTRIES, default 16, meaning the table depth; it SHALL be a power of two in the range 4..256.
REQ-002 The block SHALL have parameter TAG_W, default 8, meaning the tag bits stored per entry.
REQ-003 The block SHALL have parameter MODE, default 1, meaning 0 = static not-taken and 1 = bimodal 2-bit counters.
REQ-004 The block SHALL have port CLK, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-005 The block SHALL have port RESET_N, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port lookup_pc, input, 32 bits: fetch-stage PC.
REQ-007 The block SHALL have port pred_hit, output, 1 bit: a valid entry's tag matches lookup_pc.
REQ-008 The block SHALL have port pred_taken, output, 1 bit: predict redirect.
REQ-009 The block SHALL have port pred_target, output, 32 bits: the predicted next PC.
REQ-010 The block SHALL have port update_valid, input, 1 bit: a resolved control-transfer from Execute.
REQ-011 The block SHALL have port update_pc, input, 32 bits: PC of the resolved instruction.
REQ-012 The block SHALL have port update_type, input, 2 bits, of type br_type_t: BR, JAL or JALR.
REQ-013 The block SHALL have port update_taken, input, 1 bit: resolved direction.
REQ-014 The block SHALL have port update_target, input, 32 bits: resolved target.
REQ-015 The block SHALL have port flush_all, input, 1 bit: start a table clear.
REQ-016 The block SHALL have port busy, output, 1 bit: a clear is in progress.

Function
REQ-017 IDX_W SHALL be log2(ENTRIES); index = pc[IDX_W+1:2] and tag = pc[IDX_W+TAG_W+1:IDX_W+2], for both lookup and update.
REQ-018 Each entry SHALL hold valid, tag, a 32-bit target, a 2-bit counter and br_type_t.
REQ-019 Lookup SHALL be combinational from the current table contents: zero latency, usable in the same fetch cycle.
REQ-020 pred_hit SHALL be valid AND tag match AND not busy.
REQ-021 pred_taken SHALL be pred_hit AND (ctr[1] OR type != BR); pred_target SHALL be the entry target when pred_taken is 1, else 0.
REQ-022 When MODE = 0, pred_hit, pred_taken and pred_target SHALL be 0, and updates SHALL not write the table.
REQ-023 An update that hits SHALL set the counter as follows: taken gives saturating increment (max 3), not taken gives saturating decrement (min 0); if taken, target SHALL be overwritten.
REQ-024 An update that misses with update_taken = 1 SHALL allocate the entry: valid = 1, tag and target written, ctr = 2 (weakly taken) for BR and ctr = 3 for JAL/JALR, evicting any alias.
REQ-025 An update that misses with update_taken = 0 SHALL leave the table unchanged.
REQ-026 An update SHALL take effect at the clock edge; a same-cycle lookup of the same index SHALL see the pre-update contents (no bypass).
REQ-027 The FSM SHALL have states IDLE and CLEAR: IDLE goes to CLEAR on flush_all with ptr = 0; CLEAR clears valid[ptr] each cycle and increments ptr; CLEAR goes to IDLE after the cycle that clears ptr = ENTRIES-1.
REQ-028 busy SHALL be 1 exactly in CLEAR, for ENTRIES cycles.
REQ-029 In CLEAR, updates SHALL be ignored and flush_all SHALL be ignored (no restart).
REQ-030 flush_all and update_valid in the same IDLE cycle: flush SHALL win and the update SHALL be dropped.
REQ-031 The clear pointer SHALL be IDX_W bits wide, and the completion test SHALL not depend on wrap-around.

Reset
REQ-032 RESET_N low SHALL immediately clear all valid bits, set the FSM to IDLE, set ptr = 0 and set busy = 0, so that pred_* = 0.
REQ-033 Reset SHALL override and abort a CLEAR in progress.
REQ-034 Tag, target, counter and type storage SHALL not be reset; they are don't-care while invalid.

Structure
REQ-035 br_type_t (BR = 0, JAL = 1, JALR = 2) and the counter constants SHALL reside in the shared package otter_pkg, alongside opcode_t.
REQ-036 The 2-bit saturating counter SHALL be a sub-module sat_ctr2 (inputs: ctr, taken; output: next ctr).
REQ-037 The table SHALL be flop-based (async valid reset required); no memory macro SHALL be used.

Verification (ENTRIES=16, TAG_W=8, MODE=1)
REQ-038 Reset, then lookup 0x100 -> pred_hit = 0, pred_taken = 0, pred_target = 0.
REQ-039 Update BR at 0x100, taken, target 0x200; next cycle lookup 0x100 -> hit = 1, taken = 1, target = 0x200; the same-cycle lookup still shows a miss.
REQ-040 Counter walk at 0x100: after 2 not-taken updates, pred_taken = 0 (ctr 2->1->0); a 3rd not-taken update keeps ctr at 0; 4 taken updates -> ctr = 3, and one not-taken update keeps pred_taken = 1.
REQ-041 Alias: entry at 0x100, lookup 0x140 (same index, different tag) -> miss; taken update at 0x140 -> 0x140 hits and 0x100 misses.
REQ-042 flush_all with 3 valid entries -> busy = 1 for exactly 16 cycles, all lookups miss, a mid-clear update is dropped; after that, all 3 entries miss.
REQ-043 RESET_N low at cycle 5 of a CLEAR -> busy = 0 asynchronously, all entries miss, and the FSM is in IDLE after release.

Source files
------------

// File: rtl/otter_pkg.sv
// Shared OTTER definitions: base opcodes, control-transfer kinds and the
// 2-bit direction counter encodings used by the branch predictor.
package otter_pkg;

    typedef enum logic [6:0] {
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_BRANCH = 7'b1100011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_IMM    = 7'b0010011,
        OP_REG    = 7'b0110011,
        OP_SYS    = 7'b1110011
    } opcode_t;

    typedef enum logic [1:0] {
        BR   = 2'd0,
        JAL  = 2'd1,
        JALR = 2'd2
    } br_type_t;

    localparam logic [1:0] CTR_MIN      = 2'd0;
    localparam logic [1:0] CTR_WEAK_T   = 2'd2;
    localparam logic [1:0] CTR_STRONG_T = 2'd3;
    localparam logic [1:0] CTR_MAX      = 2'd3;

endpackage

// File: rtl/otter_branch_predictor_sat_ctr2.sv
// Two-bit saturating direction counter: next value from current value and outcome.
module sat_ctr2
    import otter_pkg::*;
(
    input  logic [1:0] ctr,
    input  logic       taken,
    output logic [1:0] ctr_next
);

    // Saturate at CTR_MAX when taken and at CTR_MIN when not taken
    always_comb begin
        ctr_next = ctr;
        case (taken)
            1'b1: begin
                if (ctr == CTR_MAX) begin
                    ctr_next = CTR_MAX;
                end else begin
                    ctr_next = ctr + 2'd1;
                end
            end
            1'b0: begin
                if (ctr == CTR_MIN) begin
                    ctr_next = CTR_MIN;
                end else begin
                    ctr_next = ctr - 2'd1;
                end
            end
            default: ctr_next = ctr;
        endcase
    end

endmodule

// File: rtl/otter_branch_predictor.sv
// Direct-mapped flop-based BTB with bimodal counters, zero-latency lookup and
// a sequential table clear that walks one entry per cycle.
module otter_branch_predictor
    import otter_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int TAG_W   = 8,
    parameter int MODE    = 1
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [31:0] lookup_pc,
    output logic        pred_hit,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        update_valid,
    input  logic [31:0] update_pc,
    input  br_type_t    update_type,
    input  logic        update_taken,
    input  logic [31:0] update_target,
    input  logic        flush_all,
    output logic        busy
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_CLEAR = 1'b1} state_t;

    state_t             state_r, state_next_s;
    logic [IDX_W-1:0]   ptr_r, ptr_next_s;
    logic               clr_en_s;

    logic [ENTRIES-1:0] valid_r;
    logic [TAG_W-1:0]   tag_mem_r  [ENTRIES];
    logic [31:0]        tgt_mem_r  [ENTRIES];
    logic [1:0]         ctr_mem_r  [ENTRIES];
    br_type_t           type_mem_r [ENTRIES];

    logic [IDX_W-1:0]   lidx_s, uidx_s;
    logic [TAG_W-1:0]   ltag_s, utag_s;
    logic               upd_ok_s, upd_hit_s, wr_en_s;
    logic [1:0]         ctr_next_s, ctr_wr_s;
    logic               unused_pc_s;

    assign lidx_s = lookup_pc[IDX_W+1:2];
    assign ltag_s = lookup_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign uidx_s = update_pc[IDX_W+1:2];
    assign utag_s = update_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign unused_pc_s = ^{lookup_pc[31:IDX_W+TAG_W+2], lookup_pc[1:0],
                           update_pc[31:IDX_W+TAG_W+2], update_pc[1:0]};
    assign busy = (state_r == ST_CLEAR);

    sat_ctr2 u_sat_ctr2 (
        .ctr      (ctr_mem_r[uidx_s]),
        .taken    (update_taken),
        .ctr_next (ctr_next_s)
    );

    // Lookup reads the table as it stands; no bypass from a same-cycle update
    always_comb begin
        pred_hit    = 1'b0;
        pred_taken  = 1'b0;
        pred_target = 32'h0;
        if ((MODE == 1) && valid_r[lidx_s] && (tag_mem_r[lidx_s] == ltag_s) && !busy) begin
            pred_hit = 1'b1;
            if (ctr_mem_r[lidx_s][1] || (type_mem_r[lidx_s] != BR)) begin
                pred_taken  = 1'b1;
                pred_target = tgt_mem_r[lidx_s];
            end else begin
                pred_taken  = 1'b0;
                pred_target = 32'h0;
            end
        end else begin
            pred_hit = 1'b0;
        end
    end

    // Update decode: flush in the same cycle wins, a clear blocks all writes
    always_comb begin
        upd_ok_s  = (MODE == 1) && update_valid && (state_r == ST_IDLE) && !flush_all;
        upd_hit_s = valid_r[uidx_s] && (tag_mem_r[uidx_s] == utag_s);
        wr_en_s   = upd_ok_s && (upd_hit_s || update_taken);
        if (upd_hit_s) begin
            ctr_wr_s = ctr_next_s;
        end else if (update_type == BR) begin
            ctr_wr_s = CTR_WEAK_T;
        end else begin
            ctr_wr_s = CTR_STRONG_T;
        end
    end

    // Clear FSM next state; completion is a compare on the last index, not a wrap
    always_comb begin
        state_next_s = state_r;
        ptr_next_s   = ptr_r;
        clr_en_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (flush_all) begin
                    state_next_s = ST_CLEAR;
                    ptr_next_s   = '0;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                clr_en_s = 1'b1;
                if (ptr_r == LAST_IDX) begin
                    state_next_s = ST_IDLE;
                    ptr_next_s   = '0;
                end else begin
                    ptr_next_s = ptr_r + IDX_W'(1);
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                ptr_next_s   = '0;
            end
        endcase
    end

    // FSM state and clear pointer
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_r <= ST_IDLE;
            ptr_r   <= '0;
        end else begin
            state_r <= state_next_s;
            ptr_r   <= ptr_next_s;
        end
    end

    // Valid bits: cleared by reset and by the clear walk, set on allocation
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            valid_r <= '0;
        end else if (clr_en_s) begin
            valid_r[ptr_r] <= 1'b0;
        end else if (wr_en_s) begin
            valid_r[uidx_s] <= 1'b1;
        end
    end

    // Payload storage is meaningless while invalid, so it carries no reset
    always_ff @(posedge CLK) begin
        if (wr_en_s) begin
            tag_mem_r[uidx_s] <= utag_s;
            ctr_mem_r[uidx_s] <= ctr_wr_s;
            if (update_taken) begin
                tgt_mem_r[uidx_s]  <= update_target;
                type_mem_r[uidx_s] <= update_type;
            end
        end
    end

endmodule
